// File: rtl/bp_pkg.sv
// Shared branch-prediction types: tracked-branch entry and instruction size.
package bp_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred_taken;
    } btq_entry_t;

endpackage

// File: rtl/branch_track_queue_if.sv
// Fetch/EX/predictor signal bundle for branch_track_queue.
// Stats outputs exist only when BTQ_STATS_EN is defined.
interface branch_track_queue_if #(parameter int unsigned DEPTH = 8);
    import bp_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            alloc_valid;
    logic [PC_W-1:0] alloc_pc;
    logic            alloc_pred_taken;
    logic            alloc_ready;
    logic            resolve_valid;
    logic            resolve_taken;
    logic [PC_W-1:0] resolve_target;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic [CW-1:0]   count;
`ifdef BTQ_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    modport master (
        output alloc_valid, alloc_pc, alloc_pred_taken,
        output resolve_valid, resolve_taken, resolve_target,
        input  alloc_ready, upd_valid, upd_pc, upd_taken,
        input  redirect_valid, redirect_pc, count
`ifdef BTQ_STATS_EN
        , input stat_branches, stat_mispredicts
`endif
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred_taken,
        input  resolve_valid, resolve_taken, resolve_target,
        output alloc_ready, upd_valid, upd_pc, upd_taken,
        output redirect_valid, redirect_pc, count
`ifdef BTQ_STATS_EN
        , output stat_branches, stat_mispredicts
`endif
    );

endinterface

// File: rtl/btq_fifo.sv
// Circular FIFO of in-flight branch entries; flush empties it in one edge.
module btq_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  btq_entry_t               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output btq_entry_t               head_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    btq_entry_t    mem_q [DEPTH];
    btq_entry_t    mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    // Self-guard so a stray push/pop can never over- or underflow the occupancy.
    always_comb begin
        push_ok = push && (count_q != CW'(DEPTH));
        pop_ok  = pop  && (count_q != '0);
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + AW'(1);
            end
            if (pop_ok) begin
                head_d = head_q + AW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy decides what is live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_c = mem_q[head_q];
    assign count  = count_q;

endmodule

// File: rtl/branch_track_queue.sv
// Tracks fetched conditional branches until EX resolves them; drives predictor
// updates and mispredict redirects. Define BTQ_STATS_EN for branch/mispredict counters.
module branch_track_queue
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_track_queue_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    btq_entry_t      head_c;
    btq_entry_t      alloc_entry_c;
    logic [CW-1:0]   count;
    logic            alloc_ready_c, pop_c, mispredict_c, push_c;

    logic            upd_valid_q, upd_valid_d;
    logic [PC_W-1:0] upd_pc_q, upd_pc_d;
    logic            upd_taken_q, upd_taken_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;

    // Full is judged on current occupancy only, so a same-cycle pop never frees a slot.
    always_comb begin
        alloc_ready_c = (count != CW'(DEPTH));
        pop_c         = bus.resolve_valid && (count != '0);
        mispredict_c  = pop_c && (bus.resolve_taken != head_c.pred_taken);
        push_c        = bus.alloc_valid && alloc_ready_c && !mispredict_c;
        alloc_entry_c = '{pc: bus.alloc_pc, pred_taken: bus.alloc_pred_taken};
    end

    btq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (alloc_entry_c),
        .pop       (pop_c),
        .flush     (mispredict_c),
        .head_c    (head_c),
        .count     (count)
    );

    // Pulses last one cycle; payloads hold their last value between pulses.
    always_comb begin
        upd_valid_d      = pop_c;
        upd_pc_d         = upd_pc_q;
        upd_taken_d      = upd_taken_q;
        redirect_valid_d = mispredict_c;
        redirect_pc_d    = redirect_pc_q;
        if (pop_c) begin
            upd_pc_d    = head_c.pc;
            upd_taken_d = bus.resolve_taken;
        end
        if (mispredict_c) begin
            redirect_pc_d = bus.resolve_taken ? bus.resolve_target
                                              : head_c.pc + PC_W'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_taken_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            upd_valid_q      <= upd_valid_d;
            upd_pc_q         <= upd_pc_d;
            upd_taken_q      <= upd_taken_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

`ifdef BTQ_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q + 32'(pop_c);
        stat_mispredicts_d = stat_mispredicts_q + 32'(mispredict_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign bus.stat_branches    = stat_branches_q;
    assign bus.stat_mispredicts = stat_mispredicts_q;
`endif

    assign bus.alloc_ready    = alloc_ready_c;
    assign bus.count          = count;
    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_pc         = upd_pc_q;
    assign bus.upd_taken      = upd_taken_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_branch_track_queue.sv
// Scoreboard bench for branch_track_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_branch_track_queue;
    import bp_pkg::*;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        redir;
        logic [31:0] rpc;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_track_queue_if #(.DEPTH(DEPTH)) bus ();
    branch_track_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t        exp_q[$];
    btq_entry_t  model_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          edge_cnt = 0;
    int unsigned m_branches = 0;
    int unsigned m_mispred  = 0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock of stimulus; the model applies the queue's rules to predict the edge.
    task automatic step(input logic av, input logic [31:0] apc, input logic ap,
                        input logic rv, input logic rt, input logic [31:0] rtg,
                        input logic r = 1'b0);
        bit   ready;
        bit   mis;
        btq_entry_t h;
        exp_t e;
        rst                  = r;
        bus.alloc_valid      = av;
        bus.alloc_pc         = apc;
        bus.alloc_pred_taken = ap;
        bus.resolve_valid    = rv;
        bus.resolve_taken    = rt;
        bus.resolve_target   = rtg;
        mis = 1'b0;
        if (r) begin
            model_q.delete();
            m_branches = 0;
            m_mispred  = 0;
        end else begin
            ready = (model_q.size() != DEPTH);
            if (rv && model_q.size() != 0) begin
                h = model_q[0];
                mis = (rt != h.pred_taken);
                e.pc    = h.pc;
                e.taken = rt;
                e.redir = mis;
                e.rpc   = rt ? rtg : h.pc + 32'd4;
                e.due   = edge_cnt + 1;
                exp_q.push_back(e);
                m_branches++;
                if (mis) begin
                    m_mispred++;
                    model_q.delete();
                end else begin
                    void'(model_q.pop_front());
                end
            end
            if (!mis && av && ready) model_q.push_back('{pc: apc, pred_taken: ap});
        end
        @(posedge clk);
        #1;
        chk("count", 32'(bus.count), 32'(model_q.size()));
        chk("alloc_ready", 32'(bus.alloc_ready), 32'(model_q.size() != DEPTH));
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic alloc(input logic [31:0] pc, input logic p);
        step(1'b1, pc, p, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic t, input logic [31:0] tgt);
        step(1'b0, 32'h0, 1'b0, 1'b1, t, tgt);
    endtask

    // Monitor: pops the scoreboard on every update pulse; flags missing or extra pulses.
    always @(negedge clk) begin
        exp_t e;
        if (bus.upd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_upd", 32'(bus.upd_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("upd_pc", bus.upd_pc, e.pc);
                chk("upd_taken", 32'(bus.upd_taken), 32'(e.taken));
                chk("redirect_valid", 32'(bus.redirect_valid), 32'(e.redir));
                if (e.redir) chk("redirect_pc", bus.redirect_pc, e.rpc);
            end
        end else begin
            if (bus.redirect_valid !== 1'b0)
                chk("spurious_redirect", 32'(bus.redirect_valid), 32'd0);
            if (exp_q.size() != 0 && exp_q[0].due <= edge_cnt) begin
                e = exp_q.pop_front();
                chk("missing_upd", 32'(bus.upd_valid), 32'd1);
            end
        end
    end

    initial begin
        logic        p;
        logic        av, rv, rt;
        logic [31:0] pc;
        #1;
        step(1'b1, 32'h55, 1'b1, 1'b1, 1'b1, 32'h66, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("rst_upd_pc", bus.upd_pc, 32'd0);
        chk("rst_upd_taken", 32'(bus.upd_taken), 32'd0);
        chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);

        // Correctly predicted taken branch
        alloc(32'h100, 1'b1);
        resolve(1'b1, 32'h200);
        idle();

        // Mispredict on oldest flushes the younger entries
        alloc(32'h100, 1'b0);
        alloc(32'h104, 1'b0);
        alloc(32'h108, 1'b0);
        resolve(1'b1, 32'h140);
        idle();

        // Predicted taken, actually falls through
        alloc(32'h10, 1'b1);
        resolve(1'b0, 32'h999);
        idle();

        // Fill, full-queue alloc+pop, then wrapping alloc/pop pairs
        for (int i = 0; i < int'(DEPTH); i++) alloc(32'h1000 + 32'(i * 4), 1'($urandom_range(0, 1)));
        step(1'b1, 32'hDEAD0, 1'b1, 1'b1, model_q[0].pred_taken, 32'h0);
        for (int i = 0; i < 20; i++)
            step(1'b1, 32'h2000 + 32'(i * 4), 1'($urandom_range(0, 1)), 1'b1, model_q[0].pred_taken, 32'h0);
        idle();

        // Resolve on empty, then reset with live entries
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        resolve(1'b1, 32'h300);
        idle();
        for (int i = 0; i < 5; i++) alloc(32'h400 + 32'(i * 4), 1'b1);
        step(1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 32'h600, 1'b1);
        idle();
        idle();

        // Random traffic, mostly correct predictions
        for (int i = 0; i < 600; i++) begin
            av = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 2) != 0);
            pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            p  = 1'($urandom_range(0, 1));
            if (model_q.size() != 0 && $urandom_range(0, 5) != 0) rt = model_q[0].pred_taken;
            else rt = 1'($urandom_range(0, 1));
            step(av, pc, p, rv, rt, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 ($urandom_range(0, 99) == 0));
        end
        idle();

`ifdef BTQ_STATS_EN
        // Ten branches, three of them mispredicted
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            p = 1'($urandom_range(0, 1));
            alloc(32'h8000 + 32'(i * 4), p);
            resolve((i == 2 || i == 5 || i == 8) ? ~p : p, 32'h9000);
        end
        idle();
        chk("stat_branches", bus.stat_branches, 32'd10);
        chk("stat_mispredicts", bus.stat_mispredicts, 32'd3);
        chk("stat_branches_model", bus.stat_branches, 32'(m_branches));
`endif

        idle();
        idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_track_queue.md
BRANCH_TRACK_QUEUE -- requirements
Module: branch_track_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of in-flight branch entries; SHALL be a power of two and at least 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: alloc_valid  input  1  fetch-stage conditional branch present (the predictor's branch_en_F).
REQ-005 Port: alloc_pc  input  32  PC of the fetched branch.
REQ-006 Port: alloc_pred_taken  input  1  predictor decision for that branch.
REQ-007 Port: alloc_ready  output  1  queue not full.
REQ-008 Port: resolve_valid  input  1  EX resolves the oldest in-flight branch.
REQ-009 Port: resolve_taken  input  1  actual outcome.
REQ-010 Port: resolve_target  input  32  computed taken target.
REQ-011 Port: upd_valid  output  1  predictor update strobe (branch_en_EX).
REQ-012 Port: upd_pc  output  32  PC of the resolved branch (PC_EX).
REQ-013 Port: upd_taken  output  1  actual outcome (branch_result).
REQ-014 Port: redirect_valid  output  1  mispredict flush and redirect to fetch.
REQ-015 Port: redirect_pc  output  32  corrected fetch PC.
REQ-016 Port: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Allocation SHALL occur on a rising edge when alloc_valid && alloc_ready, writing {alloc_pc, alloc_pred_taken} at the tail and advancing the tail modulo DEPTH.
REQ-018 alloc_ready SHALL equal (count != DEPTH), derived only from the current count; a simultaneous pop SHALL NOT make a full queue accept.
REQ-019 Resolution SHALL pop the head when resolve_valid && count != 0; resolve_valid on an empty queue SHALL be ignored with no output pulse.
REQ-020 Each pop SHALL produce, on the next cycle, a single-cycle upd_valid pulse with upd_pc = head PC and upd_taken = resolve_taken.
REQ-021 A mispredict occurs when resolve_taken != stored prediction; it SHALL produce, on the next cycle, a single-cycle redirect_valid pulse with redirect_pc = resolve_target when taken, else head PC + 4 (32-bit wrap).
REQ-022 On a mispredict edge the queue SHALL be emptied (head = tail, count = 0), and an allocation presented in the same cycle SHALL be discarded.
REQ-023 Allocation and a correct resolution in the same cycle SHALL leave count unchanged.
REQ-024 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-025 While rst is high at a rising edge: pointers, count, upd_valid, upd_pc, upd_taken, redirect_valid and redirect_pc SHALL be cleared to 0; alloc_ready SHALL read 1 in the following cycle.
REQ-026 Reset SHALL take precedence over any simultaneous alloc or resolve, and in-flight entries SHALL be dropped without any update or redirect pulse.

Configuration
REQ-027 When BTQ_STATS_EN is defined, the block SHALL add outputs stat_branches and stat_mispredicts, each 32 bits. They SHALL count valid pops and mispredicts respectively, wrap at 2^32, and be cleared by rst.
REQ-028 When BTQ_STATS_EN is undefined, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package bp_pkg SHALL hold the entry typedef {pc[31:0], pred_taken} and the constant INSTR_BYTES = 4.
REQ-030 Storage SHALL be a separate sub-module btq_fifo (parametrised FIFO with a flush input). branch_track_queue SHALL contain the compare, redirect and update logic.

Verification
REQ-031 Reset, then alloc PC 0x100 with pred 1; resolve taken with target 0x200 -> next cycle: upd_valid=1, upd_pc=0x100, upd_taken=1, redirect_valid=0.
REQ-032 Alloc 0x100 (pred 0), 0x104, 0x108; resolve first as taken, target 0x140 -> redirect_valid=1, redirect_pc=0x140, count=0 after the edge.
REQ-033 Alloc PC 0x10 with pred 1; resolve not taken -> redirect_pc=0x14, upd_taken=0.
REQ-034 Fill 8 entries -> alloc_ready=0; alloc+resolve (correct) in the same cycle -> alloc is dropped and count=7; then 20 more alloc/pop pairs with pointer wrap -> PCs popped in FIFO order.
REQ-035 Resolve on an empty queue -> no upd_valid; assert rst with 5 entries -> count=0 and no pulses.
REQ-036 With BTQ_STATS_EN: 10 branches with 3 mispredicts (no flush-lost entries) -> stat_branches=10, stat_mispredicts=3.
